// File: rtl/iq_framer.sv
// iq_framer: groups a gated I/Q sample stream into fixed-length frames and
// buffers them in a first-word-fall-through FIFO with AXI-Stream-like
// outputs. Samples that arrive while the FIFO is full are dropped and
// flagged.
// Optional build macro IQ_FRAMER_DROP_CNT_EN adds a saturating 16-bit
// dropped-sample counter output (drop_cnt).
module iq_framer #(
    parameter int DW         = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 enable,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic                 in_valid,
    input  logic                 clr_ovf,
    output logic [2*DW-1:0]      tdata_m,
    output logic                 tuser_m,
    output logic                 tlast_m,
    output logic                 tvalid_m,
    input  logic                 tready_m,
    output logic                 busy,
    output logic                 overflow
`ifdef IQ_FRAMER_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);
    // FIFO entry layout: {tlast, tuser, im, re}
    localparam int EW = 2 * DW + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            overflow_q, overflow_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr_q, rd_ptr_q;

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            sample_in;
    logic            push;
    logic            drop;
    logic            idx_last;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && tready_m;

    // A sample is only considered while framing and with the input side enabled.
    assign sample_in  = ce && in_valid && (state_q != IDLE);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push       = sample_in && (!fifo_full || pop);
    assign drop       = sample_in && !push;

    assign idx_last   = (idx_q == IW'(FRAME_LEN - 1));
    assign wr_entry   = {idx_last, (idx_q == '0), in_im, in_re};

    // Framing FSM next-state and sample index.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (push) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (enable) state_d = RUN;
                end
                RUN: begin
                    // Decide on the index after this cycle's write, so a sample
                    // landing with enable low is never left as an unfinished frame.
                    if (!enable) state_d = (idx_d == '0) ? IDLE : FINISH;
                end
                FINISH: begin
                    if (idx_d == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky overflow: a drop wins over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // State, index, overflow and FIFO pointer registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage write port.
    // NOTE: storage is not reset; emptiness comes from the pointers and outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // First-word-fall-through read: the head entry drives the outputs directly.
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign tvalid_m = !fifo_empty;
    assign tdata_m  = fifo_empty ? '0 : head[2*DW-1:0];
    assign tuser_m  = !fifo_empty && head[2*DW];
    assign tlast_m  = !fifo_empty && head[2*DW+1];
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

`ifdef IQ_FRAMER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Dropped-sample count: saturates, and a clear coinciding with a drop restarts at one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Dropped-sample counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_iq_framer.sv
// Directed testbench for iq_framer with FRAME_LEN=4, FIFO_DEPTH=4, DW=16.
// Inputs change 1 ns after each rising edge; outputs are sampled at that
// same point, so each check sees the state produced by the preceding edge.
module tb_iq_framer;

    localparam int DW = 16;

    logic            clk;
    logic            reset_n;
    logic            ce;
    logic            enable;
    logic [DW-1:0]   in_re;
    logic [DW-1:0]   in_im;
    logic            in_valid;
    logic            clr_ovf;
    logic [2*DW-1:0] tdata_m;
    logic            tuser_m;
    logic            tlast_m;
    logic            tvalid_m;
    logic            tready_m;
    logic            busy;
    logic            overflow;
`ifdef IQ_FRAMER_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    iq_framer #(
        .DW(DW),
        .FRAME_LEN(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .enable(enable),
        .in_re(in_re),
        .in_im(in_im),
        .in_valid(in_valid),
        .clr_ovf(clr_ovf),
        .tdata_m(tdata_m),
        .tuser_m(tuser_m),
        .tlast_m(tlast_m),
        .tvalid_m(tvalid_m),
        .tready_m(tready_m),
        .busy(busy),
        .overflow(overflow)
`ifdef IQ_FRAMER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present sample k as re=k, im=-k.
    task automatic drive(input int k, input logic v);
        in_re    = 16'(k);
        in_im    = 16'(-k);
        in_valid = v;
    endtask

    // Expected output vector {tvalid, tuser, tlast, im, re} for sample k.
    function automatic logic [2*DW+2:0] pkt(input int k, input logic u, input logic l);
        logic [DW-1:0] re_v;
        logic [DW-1:0] im_v;
        re_v = 16'(k);
        im_v = 16'(-k);
        return {1'b1, u, l, im_v, re_v};
    endfunction

    function automatic logic [2*DW+2:0] obs();
        return {tvalid_m, tuser_m, tlast_m, tdata_m};
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        ce       = 1'b1;
        enable   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        tready_m = 1'b1;
        #3;
        checks++;
        if ({obs(), busy, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: got out=%h busy=%b ovf=%b, expected all zero",
                     obs(), busy, overflow);
        end
`ifdef IQ_FRAMER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
`endif
        #9 reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_frames();
        enable = 1'b1;
        cyc();
        checks++;
        if ({busy, tvalid_m} !== 2'b10) begin
            errors++;
            $display("FAIL frames_start: got busy=%b tvalid=%b expected busy=1 tvalid=0",
                     busy, tvalid_m);
        end
        for (int k = 1; k <= 8; k++) begin
            drive(k, 1'b1);
            cyc();
            checks++;
            if (obs() !== pkt(k, (k == 1 || k == 5), (k == 4 || k == 8))) begin
                errors++;
                $display("FAIL frames re=%0d: got %h expected %h",
                         k, obs(), pkt(k, (k == 1 || k == 5), (k == 4 || k == 8)));
            end
        end
        drive(0, 1'b0);
        cyc();
        checks++;
        if (tvalid_m !== 1'b0) begin
            errors++;
            $display("FAIL frames_drained: got tvalid=%b expected 0", tvalid_m);
        end
        enable = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frames_idle_at_boundary: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_finish();
        enable = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) enable = 1'b0;
            drive(k, 1'b1);
            cyc();
            if (k <= 4) begin
                checks++;
                if (obs() !== pkt(k, (k == 1), (k == 4))) begin
                    errors++;
                    $display("FAIL finish re=%0d: got %h expected %h",
                             k, obs(), pkt(k, (k == 1), (k == 4)));
                end
            end
            if (k == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL finish_busy_mid: got busy=%b expected 1", busy);
                end
            end
            if (k == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL finish_idle: got busy=%b expected 0", busy);
                end
            end
            if (k == 5) begin
                checks++;
                if (obs() !== '0) begin
                    errors++;
                    $display("FAIL finish_discard: got %h expected 0", obs());
                end
            end
        end
        drive(0, 1'b0);
        cyc();
    endtask

    task automatic test_overflow();
        tready_m = 1'b0;
        enable   = 1'b1;
        cyc();
        for (int k = 1; k <= 6; k++) begin
            drive(k, 1'b1);
            // Clear coinciding with a drop must leave the flag set.
            clr_ovf = (k == 5);
            cyc();
            clr_ovf = 1'b0;
            if (k == 4) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_before_full: got %b expected 0", overflow);
                end
            end
            if (k == 5) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_drop_vs_clear: got %b expected 1", overflow);
                end
            end
        end
        checks++;
        if ({overflow, obs()} !== {1'b1, pkt(1, 1'b1, 1'b0)}) begin
            errors++;
            $display("FAIL ovf_held_head: got ovf=%b out=%h expected ovf=1 out=%h",
                     overflow, obs(), pkt(1, 1'b1, 1'b0));
        end
`ifdef IQ_FRAMER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt);
        end
`endif
        drive(0, 1'b0);
        tready_m = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (obs() !== pkt(j, (j == 1), (j == 4))) begin
                errors++;
                $display("FAIL ovf_drain re=%0d: got %h expected %h",
                         j, obs(), pkt(j, (j == 1), (j == 4)));
            end
            cyc();
        end
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL ovf_drain_empty: got %h expected 0", obs());
        end
        for (int k = 5; k <= 8; k++) begin
            if (k == 6) enable = 1'b0;
            drive(k, 1'b1);
            cyc();
            checks++;
            if (obs() !== pkt(k, (k == 5), (k == 8))) begin
                errors++;
                $display("FAIL ovf_next_frame re=%0d: got %h expected %h",
                         k, obs(), pkt(k, (k == 5), (k == 8)));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_frame_done: got busy=%b expected 0", busy);
        end
        drive(0, 1'b0);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
`ifdef IQ_FRAMER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovf_drop_cnt_clear: got %0d expected 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_full_pop();
        tready_m = 1'b0;
        enable   = 1'b1;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            drive(k, 1'b1);
            cyc();
        end
        tready_m = 1'b1;
        drive(5, 1'b1);
        cyc();
        checks++;
        if ({overflow, obs()} !== {1'b0, pkt(2, 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL full_pop: got ovf=%b out=%h expected ovf=0 out=%h",
                     overflow, obs(), pkt(2, 1'b0, 1'b0));
        end
        enable = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            drive(k, 1'b1);
            cyc();
            checks++;
            if (obs() !== pkt(k - 3, (k - 3 == 5), (k - 3 == 4))) begin
                errors++;
                $display("FAIL full_stream head=%0d: got %h expected %h",
                         k - 3, obs(), pkt(k - 3, (k - 3 == 5), (k - 3 == 4)));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_frame_done: got busy=%b expected 0", busy);
        end
        drive(0, 1'b0);
        for (int h = 6; h <= 8; h++) begin
            cyc();
            checks++;
            if (obs() !== pkt(h, 1'b0, (h == 8))) begin
                errors++;
                $display("FAIL full_drain re=%0d: got %h expected %h",
                         h, obs(), pkt(h, 1'b0, (h == 8)));
            end
        end
        cyc();
        checks++;
        if ({overflow, obs()} !== '0) begin
            errors++;
            $display("FAIL full_end: got ovf=%b out=%h expected all zero", overflow, obs());
        end
    endtask

    task automatic test_reset_mid();
        tready_m = 1'b0;
        enable   = 1'b1;
        cyc();
        drive(1, 1'b1);
        cyc();
        drive(2, 1'b1);
        cyc();
        checks++;
        if (obs() !== pkt(1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rstmid_buffered: got %h expected %h", obs(), pkt(1, 1'b1, 1'b0));
        end
        drive(0, 1'b0);
        enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({obs(), busy, overflow} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got out=%h busy=%b ovf=%b expected all zero",
                     obs(), busy, overflow);
        end
        #2 reset_n = 1'b1;
        cyc();
        tready_m = 1'b1;
        enable   = 1'b1;
        cyc();
        for (int k = 9; k <= 12; k++) begin
            if (k == 10) enable = 1'b0;
            drive(k, 1'b1);
            cyc();
            checks++;
            if (obs() !== pkt(k, (k == 9), (k == 12))) begin
                errors++;
                $display("FAIL rstmid_refill re=%0d: got %h expected %h",
                         k, obs(), pkt(k, (k == 9), (k == 12)));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done: got busy=%b expected 0", busy);
        end
        drive(0, 1'b0);
        cyc();
    endtask

    task automatic test_ce();
        enable = 1'b1;
        cyc();
        tready_m = 1'b0;
        drive(1, 1'b1);
        cyc();
        drive(2, 1'b1);
        cyc();
        checks++;
        if (obs() !== pkt(1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL ce_buffered: got %h expected %h", obs(), pkt(1, 1'b1, 1'b0));
        end
        ce       = 1'b0;
        tready_m = 1'b1;
        drive(3, 1'b1);
        cyc();
        checks++;
        if (obs() !== pkt(2, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL ce_off_drain: got %h expected %h", obs(), pkt(2, 1'b0, 1'b0));
        end
        cyc();
        cyc();
        checks++;
        if ({busy, obs()} !== {1'b1, {(2*DW+3){1'b0}}}) begin
            errors++;
            $display("FAIL ce_off_frozen: got busy=%b out=%h expected busy=1 out=0",
                     busy, obs());
        end
        ce = 1'b1;
        cyc();
        checks++;
        if (obs() !== pkt(3, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL ce_resume re=3: got %h expected %h", obs(), pkt(3, 1'b0, 1'b0));
        end
        enable = 1'b0;
        drive(4, 1'b1);
        cyc();
        checks++;
        if ({busy, obs()} !== {1'b0, pkt(4, 1'b0, 1'b1)}) begin
            errors++;
            $display("FAIL ce_resume re=4: got busy=%b out=%h expected busy=0 out=%h",
                     busy, obs(), pkt(4, 1'b0, 1'b1));
        end
        drive(0, 1'b0);
        cyc();
    endtask

    initial begin
        test_reset();
        test_frames();
        test_finish();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_ce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
